mult_err_stats: RTL and testbench

- Downstream error-characterisation stage for the 8x8 approximate multipliers in the library.
- Consumes each operand pair plus the approximate product, computes the exact product internally, and accumulates error statistics over a programmed sample count: sample count, error count, sum of error distance (ED), max ED with its operands.
- Used in the characterisation harness and on-chip self-test wrappers to score a multiplier variant.

---
 rtl/mult_stats_pkg.sv | 37 +++
 rtl/err_dist_unit.sv | 55 +++++
 rtl/mult_err_stats.sv | 153 +++++++++++++++
 tb/tb_mult_err_stats.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_stats_pkg.sv
// Shared types and helpers for the approximate-multiplier error statistics block.
// Consumed by err_dist_unit and mult_err_stats.
package mult_stats_pkg;

   localparam int DEF_W     = 8;
   localparam int DEF_CNT_W = 17;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic int sum_w_calc(input int w, input int cnt_w);
      return 2 * w + cnt_w;
   endfunction

   function automatic int sq_w_calc(input int w, input int cnt_w);
      return 4 * w + cnt_w;
   endfunction

   // Returns {overflow, min(acc + inc, 2^width - 1)}; width must be <= 64.
   function automatic logic [64:0] sat_add(input logic [63:0] acc,
                                           input logic [63:0] inc,
                                           input int          width);
      logic [64:0] full;
      logic [64:0] lim;
      full = {1'b0, acc} + {1'b0, inc};
      lim  = (65'd1 << width) - 65'd1;
      if (full > lim) begin
         return {1'b1, lim[63:0]};
      end
      return {1'b0, full[63:0]};
   endfunction

endpackage

// File: rtl/err_dist_unit.sv
// Two-stage error-distance pipe: S1 holds operands and the exact product,
// S2 holds |exact - approx| together with the operands that produced it.
module err_dist_unit
   import mult_stats_pkg::*;
#(
   parameter int W = DEF_W
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   input  logic [W-1:0]   in_a,
   input  logic [W-1:0]   in_b,
   input  logic [2*W-1:0] in_r,
   output logic           s1_valid,
   output logic           s2_valid,
   output logic [W-1:0]   s2_a,
   output logic [W-1:0]   s2_b,
   output logic [2*W-1:0] s2_ed
);

   logic [W-1:0]   s1_a;
   logic [W-1:0]   s1_b;
   logic [2*W-1:0] s1_r;
   logic [2*W-1:0] s1_exact;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_r     <= '0;
         s1_exact <= '0;
         s2_valid <= 1'b0;
         s2_a     <= '0;
         s2_b     <= '0;
         s2_ed    <= '0;
      end else begin
         s1_valid <= in_valid;
         // Data registers load only on real samples so bubbles cannot disturb them.
         if (in_valid) begin
            s1_a     <= in_a;
            s1_b     <= in_b;
            s1_r     <= in_r;
            s1_exact <= (2*W)'(in_a) * (2*W)'(in_b);
         end
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_a  <= s1_a;
            s2_b  <= s1_b;
            s2_ed <= (s1_exact >= s1_r) ? (s1_exact - s1_r) : (s1_r - s1_exact);
         end
      end
   end

endmodule

// File: rtl/mult_err_stats.sv
// Error-statistics scorer for 8x8 approximate multipliers over a programmed sample count.
// Optional MULT_ERR_SQ_EN adds o_sum_sq (sum of squared error distance).
module mult_err_stats
   import mult_stats_pkg::*;
#(
   parameter int W     = DEF_W,
   parameter int CNT_W = DEF_CNT_W,
   parameter int SUM_W = sum_w_calc(W, CNT_W)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] cfg_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_a,
   input  logic [W-1:0]     in_b,
   input  logic [2*W-1:0]   in_r,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] o_count,
   output logic [CNT_W-1:0] o_err_cnt,
   output logic [SUM_W-1:0] o_sum_ed,
   output logic [2*W-1:0]   o_max_ed,
   output logic [W-1:0]     o_max_a,
   output logic [W-1:0]     o_max_b,
   output logic             o_sum_sat
`ifdef MULT_ERR_SQ_EN
   ,
   output logic [sq_w_calc(W, CNT_W)-1:0] o_sum_sq
`endif
);

   // Handshake: a sample transfers on a cycle where in_valid && in_ready; in_ready
   // depends only on state and the accepted count, never on in_valid.

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] accepted;
   logic [CNT_W-1:0] accepted_next;
   logic [CNT_W-1:0] n_lat;
   logic             xfer;
   logic             clear;

   logic             s1_valid;
   logic             s2_valid;
   logic [W-1:0]     s2_a;
   logic [W-1:0]     s2_b;
   logic [2*W-1:0]   s2_ed;

   logic [64:0]      sum_add;
   logic             sum_hit;
   logic             sat_hit;

   assign in_ready      = (state == RUN) && (accepted != n_lat);
   assign busy          = (state == RUN) || (state == DRAIN);
   assign done          = (state == DONE);
   assign xfer          = in_valid && in_ready;
   assign clear         = start && ((state == IDLE) || (state == DONE));
   assign accepted_next = accepted + CNT_W'(xfer);

   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE: if (start) state_next = RUN;
         RUN:        if (accepted_next == n_lat) state_next = DRAIN;
         DRAIN:      if (!s1_valid && !s2_valid) state_next = DONE;
         default:    state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         accepted <= '0;
         n_lat    <= '0;
      end else begin
         state <= state_next;
         if (clear) begin
            accepted <= '0;
            n_lat    <= cfg_n;
         end else if (xfer) begin
            accepted <= accepted_next;
         end
      end
   end

   err_dist_unit #(.W(W)) u_edu (
      .clk      (clk),
      .rst      (rst),
      .in_valid (xfer),
      .in_a     (in_a),
      .in_b     (in_b),
      .in_r     (in_r),
      .s1_valid (s1_valid),
      .s2_valid (s2_valid),
      .s2_a     (s2_a),
      .s2_b     (s2_b),
      .s2_ed    (s2_ed)
   );

   // The helper returns a clamped value, so any set bit at or above SUM_W means overflow.
   assign sum_add = sat_add(64'(o_sum_ed), 64'(s2_ed), SUM_W);
   assign sum_hit = |sum_add[64:SUM_W];

`ifdef MULT_ERR_SQ_EN
   localparam int SQ_W = sq_w_calc(W, CNT_W);
   logic [4*W-1:0] ed_sq;
   logic [64:0]    sq_add;
   logic           sq_hit;

   assign ed_sq   = (4*W)'(s2_ed) * (4*W)'(s2_ed);
   assign sq_add  = sat_add(64'(o_sum_sq), 64'(ed_sq), SQ_W);
   assign sq_hit  = |sq_add[64:SQ_W];
   assign sat_hit = sum_hit | sq_hit;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         o_sum_sq <= '0;
      end else if (s2_valid) begin
         o_sum_sq <= sq_add[SQ_W-1:0];
      end
   end
`else
   assign sat_hit = sum_hit;
`endif

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         o_count   <= '0;
         o_err_cnt <= '0;
         o_sum_ed  <= '0;
         o_max_ed  <= '0;
         o_max_a   <= '0;
         o_max_b   <= '0;
         o_sum_sat <= 1'b0;
      end else if (s2_valid) begin
         o_count   <= o_count + CNT_W'(1);
         if (s2_ed != '0) begin
            o_err_cnt <= o_err_cnt + CNT_W'(1);
         end
         o_sum_ed  <= sum_add[SUM_W-1:0];
         o_sum_sat <= o_sum_sat | sat_hit;
         // Strict compare keeps the earliest sample on ties.
         if (s2_ed > o_max_ed) begin
            o_max_ed <= s2_ed;
            o_max_a  <= s2_a;
            o_max_b  <= s2_b;
         end
      end
   end

endmodule

// File: tb/tb_mult_err_stats.sv
// Directed and randomized checks of mult_err_stats against a per-run arithmetic model.
// A second instance with a 16-bit ED accumulator exercises saturation.
module tb_mult_err_stats;

   localparam int W      = 8;
   localparam int CNT_W  = 17;
   localparam int SUM_W  = 2 * W + CNT_W;
   localparam int SAT_W  = 16;
   localparam int SQ_W   = 4 * W + CNT_W;

   logic             clk;
   logic             rst;
   logic             start;
   logic [CNT_W-1:0] cfg_n;
   logic             in_valid;
   logic [W-1:0]     in_a;
   logic [W-1:0]     in_b;
   logic [2*W-1:0]   in_r;

   logic             in_ready, busy, done, o_sum_sat;
   logic [CNT_W-1:0] o_count, o_err_cnt;
   logic [SUM_W-1:0] o_sum_ed;
   logic [2*W-1:0]   o_max_ed;
   logic [W-1:0]     o_max_a, o_max_b;

   logic             s_in_ready, s_busy, s_done, s_sum_sat;
   logic [CNT_W-1:0] s_count, s_err_cnt;
   logic [SAT_W-1:0] s_sum_ed;
   logic [2*W-1:0]   s_max_ed;
   logic [W-1:0]     s_max_a, s_max_b;
`ifdef MULT_ERR_SQ_EN
   logic [SQ_W-1:0]  o_sum_sq, s_sum_sq;
`endif

   mult_err_stats #(.W(W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .cfg_n(cfg_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_r(in_r),
      .busy(busy), .done(done),
      .o_count(o_count), .o_err_cnt(o_err_cnt), .o_sum_ed(o_sum_ed),
      .o_max_ed(o_max_ed), .o_max_a(o_max_a), .o_max_b(o_max_b),
      .o_sum_sat(o_sum_sat)
`ifdef MULT_ERR_SQ_EN
      , .o_sum_sq(o_sum_sq)
`endif
   );

   mult_err_stats #(.W(W), .CNT_W(CNT_W), .SUM_W(SAT_W)) dut_sat (
      .clk(clk), .rst(rst), .start(start), .cfg_n(cfg_n),
      .in_valid(in_valid), .in_ready(s_in_ready),
      .in_a(in_a), .in_b(in_b), .in_r(in_r),
      .busy(s_busy), .done(s_done),
      .o_count(s_count), .o_err_cnt(s_err_cnt), .o_sum_ed(s_sum_ed),
      .o_max_ed(s_max_ed), .o_max_a(s_max_a), .o_max_b(s_max_b),
      .o_sum_sat(s_sum_sat)
`ifdef MULT_ERR_SQ_EN
      , .o_sum_sq(s_sum_sq)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [W-1:0]   qa[$];
   logic [W-1:0]   qb[$];
   logic [2*W-1:0] qr[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push(input int a, input int b, input int r);
      qa.push_back(W'(a));
      qb.push_back(W'(b));
      qr.push_back((2*W)'(r));
   endtask

   task automatic push_random(input int cnt);
      int a, b, ex, r;
      for (int i = 0; i < cnt; i++) begin
         a  = $urandom_range(255);
         b  = $urandom_range(255);
         ex = a * b;
         case ($urandom_range(3))
            0:       r = ex;
            1:       r = ex ^ (1 << $urandom_range(5));
            2:       r = $urandom_range(65535);
            default: r = (ex + $urandom_range(20)) % 65536;
         endcase
         push(a, b, r);
      end
   endtask

   // Start a run of n samples from the queues and check handshake, latency and final stats.
   task automatic run(input int n, input int gap_pct, input string tag);
      logic [63:0] sum, sq, lim1, lim2, limsq, maxed;
      logic [W-1:0] ma, mb;
      int err, ex, rr, ed, acc, idx, guard, lat;
      bit vld;

      sum = 0; sq = 0; err = 0; maxed = 0; ma = 0; mb = 0;
      for (int i = 0; i < n; i++) begin
         ex = int'(qa[i]) * int'(qb[i]);
         rr = int'(qr[i]);
         ed = (ex >= rr) ? ex - rr : rr - ex;
         if (ed != 0) err++;
         sum += 64'(ed);
         sq  += 64'(ed) * 64'(ed);
         if (64'(ed) > maxed) begin
            maxed = 64'(ed);
            ma = qa[i];
            mb = qb[i];
         end
      end
      lim1  = (64'd1 << SUM_W) - 1;
      lim2  = (64'd1 << SAT_W) - 1;
      limsq = (64'd1 << SQ_W) - 1;

      @(negedge clk);
      start = 1'b1; cfg_n = CNT_W'(n); in_valid = 1'b0;
      @(negedge clk);
      start = 1'b0; cfg_n = CNT_W'($urandom);

      acc = 0; idx = 0; guard = 0;
      while (acc < n && guard < 4000) begin
         chk({tag, ".ready_run"}, 64'(in_ready), 64'd1);
         vld = ($urandom_range(99) >= gap_pct);
         in_valid = vld;
         in_a = vld ? qa[idx] : W'($urandom);
         in_b = vld ? qb[idx] : W'($urandom);
         in_r = vld ? qr[idx] : (2*W)'($urandom);
         @(negedge clk);
         if (vld) begin
            acc++;
            idx++;
         end
         guard++;
      end
      chk({tag, ".xfers"}, 64'(acc), 64'(n));

      // keep offering data while draining; none of it may be taken
      in_valid = 1'b1;
      lat = 1;
      while (!done && lat < 50) begin
         chk({tag, ".ready_drain"}, 64'(in_ready), 64'd0);
         chk({tag, ".busy"}, 64'(busy), 64'd1);
         in_a = W'($urandom); in_b = W'($urandom); in_r = (2*W)'($urandom);
         @(negedge clk);
         lat++;
      end
      if (n > 0) chk({tag, ".done_lat"}, 64'(lat), 64'd4);
      else       chk({tag, ".done_lat_le3"}, 64'(lat <= 3), 64'd1);

      repeat (3) begin
         in_valid = 1'(($urandom_range(1)));
         in_a = W'($urandom); in_b = W'($urandom); in_r = (2*W)'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk({tag, ".done_hold"}, 64'(done), 64'd1);
      chk({tag, ".busy_done"}, 64'(busy), 64'd0);
      chk({tag, ".count"},   64'(o_count),   64'(n));
      chk({tag, ".err_cnt"}, 64'(o_err_cnt), 64'(err));
      chk({tag, ".sum_ed"},  64'(o_sum_ed),  (sum > lim1) ? lim1 : sum);
      chk({tag, ".max_ed"},  64'(o_max_ed),  maxed);
      chk({tag, ".max_a"},   64'(o_max_a),   64'(ma));
      chk({tag, ".max_b"},   64'(o_max_b),   64'(mb));
`ifdef MULT_ERR_SQ_EN
      chk({tag, ".sum_sq"},  64'(o_sum_sq),  (sq > limsq) ? limsq : sq);
      chk({tag, ".sat"},     64'(o_sum_sat), 64'((sum > lim1) || (sq > limsq)));
      chk({tag, ".s16_sat"}, 64'(s_sum_sat), 64'((sum > lim2) || (sq > limsq)));
`else
      chk({tag, ".sat"},     64'(o_sum_sat), 64'(sum > lim1));
      chk({tag, ".s16_sat"}, 64'(s_sum_sat), 64'(sum > lim2));
`endif
      chk({tag, ".s16_sum"}, 64'(s_sum_ed),  (sum > lim2) ? lim2 : sum);
      chk({tag, ".s16_count"}, 64'(s_count), 64'(n));
      qa.delete(); qb.delete(); qr.delete();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".count"},   64'(o_count),   64'd0);
      chk({tag, ".err_cnt"}, 64'(o_err_cnt), 64'd0);
      chk({tag, ".sum_ed"},  64'(o_sum_ed),  64'd0);
      chk({tag, ".max_ed"},  64'(o_max_ed),  64'd0);
      chk({tag, ".max_a"},   64'(o_max_a),   64'd0);
      chk({tag, ".max_b"},   64'(o_max_b),   64'd0);
      chk({tag, ".sat"},     64'(o_sum_sat), 64'd0);
      chk({tag, ".busy"},    64'(busy),      64'd0);
      chk({tag, ".done"},    64'(done),      64'd0);
      chk({tag, ".ready"},   64'(in_ready),  64'd0);
`ifdef MULT_ERR_SQ_EN
      chk({tag, ".sum_sq"},  64'(o_sum_sq),  64'd0);
`endif
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; cfg_n = '0; in_valid = 1'b0;
      in_a = '0; in_b = '0; in_r = '0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;

      // exact products
      push(3, 5, 15); push(255, 255, 65025); push(0, 7, 0); push(16, 16, 256);
      run(4, 0, "exact");

      // known errors with tied ED
      push(10, 10, 96); push(20, 3, 64); push(7, 7, 45);
      run(3, 0, "known");

      // backpressure: offered continuously, only two may be taken
      push(9, 9, 80); push(2, 200, 401); push(1, 1, 1); push(1, 1, 1); push(1, 1, 1);
      run(2, 0, "bp");

      // zero-length run
      run(0, 0, "n0");

      // saturation of the 16-bit accumulator
      push(255, 255, 0); push(255, 255, 0);
      run(2, 0, "sat");
      push(1, 1, 1);
      run(1, 0, "sat_clear");

      // abort in the middle of a run
      push_random(5);
      @(negedge clk);
      start = 1'b1; cfg_n = CNT_W'(5);
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b1; in_a = qa[0]; in_b = qb[0]; in_r = qr[0];
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_all_zero("midrst");
      rst = 1'b0;
      repeat (4) @(negedge clk);
      in_valid = 1'b0;
      chk({"midrst", ".count_later"}, 64'(o_count), 64'd0);
      chk({"midrst", ".busy_later"}, 64'(busy), 64'd0);
      qa.delete(); qb.delete(); qr.delete();

      // randomized runs with bubbles
      for (int t = 0; t < 6; t++) begin
         int n;
         n = $urandom_range(24, 1);
         push_random(n + 2);
         run(n, 30, $sformatf("rand%0d", t));
      end
      push_random(200);
      run(200, 20, "rand_long");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
